pattern_loader: RTL and testbench

PATTERN_LOADER -- requirements
Module: pattern_loader

---
 rtl/pattern_loader.sv | 152 +++++++++++++++
 tb/tb_pattern_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_loader.sv
// Frame loader: accepts pattern bytes and shifts them MSB-first into a serial
// pattern buffer, returning each displaced buffer byte on rd_data.
module pattern_loader #(
   parameter int unsigned BUFFER_WIDTH = 8,
   parameter int unsigned BUFFER_SIZE  = 32
) (
   input  logic                    sclk,
   input  logic                    rstn,
   input  logic                    start,
   input  logic [BUFFER_WIDTH-1:0] in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic                    ssel,
   output logic                    sin,
   input  logic                    sout,
   output logic [BUFFER_WIDTH-1:0] rd_data,
   output logic                    rd_valid,
   output logic                    busy,
   output logic                    done
);

   localparam int unsigned BYTE_CNT_W = $clog2(BUFFER_SIZE);
   localparam int unsigned BIT_CNT_W  = $clog2(BUFFER_WIDTH);
   localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BUFFER_SIZE - 1);
   localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(BUFFER_WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_BYTE = 2'd1,
      S_SHIFT     = 2'd2
   } state_t;

   state_t                  r_state;
   logic [BYTE_CNT_W-1:0]   r_byte_cnt;
   logic [BIT_CNT_W-1:0]    r_bit_cnt;
   logic [BUFFER_WIDTH-1:0] r_shreg;
   logic [BUFFER_WIDTH-1:0] r_cap;
   logic [BUFFER_WIDTH-1:0] r_rd_data;
   logic                    r_rd_valid;
   logic                    r_done;
   logic                    r_in_ready;
   logic                    r_ssel;
   logic                    r_sin;
   logic                    r_busy;

   state_t                  w_state_nxt;
   logic [BYTE_CNT_W-1:0]   w_byte_cnt_nxt;
   logic [BIT_CNT_W-1:0]    w_bit_cnt_nxt;
   logic [BUFFER_WIDTH-1:0] w_shreg_nxt;
   logic [BUFFER_WIDTH-1:0] w_cap_nxt;
   logic [BUFFER_WIDTH-1:0] w_rd_data_nxt;
   logic                    w_rd_valid_nxt;
   logic                    w_done_nxt;
   logic                    w_in_ready_nxt;
   logic                    w_ssel_nxt;
   logic                    w_sin_nxt;
   logic                    w_busy_nxt;

   // State, counters, datapath and output registers.
   always_ff @(posedge sclk) begin
      if (!rstn) begin
         r_state    <= S_IDLE;
         r_byte_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shreg    <= '0;
         r_cap      <= '0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_done     <= 1'b0;
         r_in_ready <= 1'b0;
         r_ssel     <= 1'b0;
         r_sin      <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_byte_cnt <= w_byte_cnt_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_shreg    <= w_shreg_nxt;
         r_cap      <= w_cap_nxt;
         r_rd_data  <= w_rd_data_nxt;
         r_rd_valid <= w_rd_valid_nxt;
         r_done     <= w_done_nxt;
         r_in_ready <= w_in_ready_nxt;
         r_ssel     <= w_ssel_nxt;
         r_sin      <= w_sin_nxt;
         r_busy     <= w_busy_nxt;
      end
   end

   // Next-state and datapath; outputs are derived from the next state so the
   // registered outputs line up with the state they describe.
   always_comb begin
      w_state_nxt    = r_state;
      w_byte_cnt_nxt = r_byte_cnt;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_shreg_nxt    = r_shreg;
      w_cap_nxt      = r_cap;
      w_rd_data_nxt  = r_rd_data;
      w_rd_valid_nxt = 1'b0;
      w_done_nxt     = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt    = S_WAIT_BYTE;
               w_byte_cnt_nxt = '0;
            end
         end
         S_WAIT_BYTE: begin
            if (in_valid) begin
               w_shreg_nxt   = in_data;
               w_bit_cnt_nxt = '0;
               w_state_nxt   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            // cap collects the buffer MSB as it is displaced by each shift.
            w_shreg_nxt   = {r_shreg[BUFFER_WIDTH-2:0], 1'b0};
            w_cap_nxt     = {r_cap[BUFFER_WIDTH-2:0], sout};
            w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
            if (r_bit_cnt == LAST_BIT) begin
               w_rd_data_nxt  = {r_cap[BUFFER_WIDTH-2:0], sout};
               w_rd_valid_nxt = 1'b1;
               if (r_byte_cnt < LAST_BYTE) begin
                  w_byte_cnt_nxt = r_byte_cnt + BYTE_CNT_W'(1);
                  w_state_nxt    = S_WAIT_BYTE;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_done_nxt  = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_in_ready_nxt = (w_state_nxt == S_WAIT_BYTE);
      w_ssel_nxt     = (w_state_nxt == S_SHIFT);
      w_busy_nxt     = (w_state_nxt != S_IDLE);
      w_sin_nxt      = (w_state_nxt == S_SHIFT) ? w_shreg_nxt[BUFFER_WIDTH-1] : 1'b0;
   end

   assign in_ready = r_in_ready;
   assign ssel     = r_ssel;
   assign sin      = r_sin;
   assign rd_data  = r_rd_data;
   assign rd_valid = r_rd_valid;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

// File: tb/tb_pattern_loader.sv
// Bench for pattern_loader: serial pattern buffer environment, byte-level
// reference model, and a scoreboard checked by an independent monitor.
module tb_pattern_loader;

   localparam int unsigned NB = 32;
   localparam int unsigned BW = 8 * NB;

   logic       sclk = 1'b0;
   logic       rstn = 1'b0;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       sout;
   logic       in_ready, ssel, sin, rd_valid, busy, done;
   logic [7:0] rd_data;

   always #5 sclk = ~sclk;

   pattern_loader #(.BUFFER_WIDTH(8), .BUFFER_SIZE(NB)) dut (
      .sclk(sclk), .rstn(rstn), .start(start), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .ssel(ssel), .sin(sin),
      .sout(sout), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
      .done(done)
   );

   // Downstream pattern buffer: byte k occupies bits [8k+7:8k], sout is its top bit.
   logic [BW-1:0] pbuf = '0;
   logic [BW-1:0] pl_val = '0;
   logic          pl_en = 1'b0;
   always @(posedge sclk) begin
      if (pl_en) pbuf <= pl_val;
      else if (ssel) pbuf <= {pbuf[BW-2:0], sin};
   end
   assign sout = pbuf[BW-1];

   // Reference model of buffer contents, updated a whole byte at a time.
   logic [BW-1:0] mb = '0;
   logic [7:0]    fd [NB];

   typedef struct packed {
      logic [7:0] rd;
      logic [7:0] sb;
      logic       last;
   } exp_t;
   exp_t sbq[$];

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every rd_valid pulse.
   initial begin : mon
      logic [7:0] sbits;
      int         cnt;
      logic       prev_ssel;
      exp_t       e;
      sbits = '0;
      cnt = 0;
      prev_ssel = 1'b0;
      forever begin
         @(negedge sclk);
         if (ssel) begin
            sbits = {sbits[6:0], sin};
            cnt++;
            chk("in_ready_during_shift", 32'(in_ready), 32'd0);
         end
         if (rd_valid) begin
            if (sbq.size() == 0) begin
               chk("unexpected_rd_valid", 32'(rd_valid), 32'd0);
            end else begin
               e = sbq.pop_front();
               chk("rd_data", 32'(rd_data), 32'(e.rd));
               chk("sin_sequence", 32'(sbits), 32'(e.sb));
               chk("ssel_cycles_per_byte", 32'(cnt), 32'd8);
               chk("rd_valid_follows_shift", 32'(prev_ssel), 32'd1);
               chk("done_with_last_rd", 32'(done), 32'(e.last));
            end
            cnt = 0;
         end else begin
            chk("done_without_rd_valid", 32'(done), 32'd0);
            if (!busy) cnt = 0;
         end
         prev_ssel = ssel;
      end
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 200) begin
         @(negedge sclk);
         n++;
      end
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input logic last);
      if (gap > 0) begin
         in_valid = 1'b0;
         wait_ready();
         for (int g = 0; g < gap; g++) begin
            chk("stall_ssel", 32'(ssel), 32'd0);
            chk("stall_in_ready", 32'(in_ready), 32'd1);
            @(negedge sclk);
         end
      end
      in_valid = 1'b1;
      in_data  = b;
      wait_ready();
      sbq.push_back(exp_t'{rd: mb[BW-1 -: 8], sb: b, last: last});
      mb = {mb[BW-9:0], b};
      @(negedge sclk);
   endtask

   // gap_mode < 0 picks a random stall per byte; abort_byte/poke_byte < 0 disable.
   task automatic run_frame(input int gap_mode, input int abort_byte, input int poke_byte);
      int            gap;
      int            n;
      logic [BW-1:0] msave;
      start = 1'b1;
      @(negedge sclk);
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      for (int i = 0; i < int'(NB); i++) begin
         gap = (gap_mode < 0) ? int'($urandom_range(0, 3)) : gap_mode;
         msave = mb;
         send_byte(fd[i], gap, (i == int'(NB) - 1));
         if (i == poke_byte) begin
            start = 1'b1;
            @(negedge sclk);
            start = 1'b0;
            chk("start_ignored_in_shift", 32'(ssel), 32'd1);
         end
         if (i == abort_byte) begin
            repeat (3) @(negedge sclk);
            chk("abort_on_shift_cycle", 32'(ssel), 32'd1);
            rstn = 1'b0;
            @(negedge sclk);
            chk("abort_ssel", 32'(ssel), 32'd0);
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_in_ready", 32'(in_ready), 32'd0);
            chk("abort_done", 32'(done), 32'd0);
            chk("abort_rd_valid", 32'(rd_valid), 32'd0);
            rstn = 1'b1;
            in_valid = 1'b0;
            void'(sbq.pop_back());
            mb = {msave[BW-5:0], fd[i][7:4]};
            @(negedge sclk);
            chk("abort_buffer", 32'(pbuf == mb), 32'd1);
            return;
         end
      end
      n = 0;
      while (busy && n < 20) begin
         @(negedge sclk);
         n++;
      end
      chk("busy_low_after_frame", 32'(busy), 32'd0);
      in_valid = 1'b0;
      @(negedge sclk);
      chk("frame_buffer_contents", 32'(pbuf == mb), 32'd1);
      chk("idle_ssel_after_frame", 32'(ssel), 32'd0);
   endtask

   task automatic check_index_pattern();
      for (int k = 0; k < int'(NB); k++)
         chk("buffer_byte_equals_index", 32'(pbuf[8*k +: 8]), 32'(k));
   endtask

   task automatic fill_random();
      for (int i = 0; i < int'(NB); i++) fd[i] = 8'($urandom);
   endtask

   initial begin : stim
      @(negedge sclk);
      repeat (3) @(negedge sclk);
      rstn = 1'b1;
      chk("reset_ssel", 32'(ssel), 32'd0);
      chk("reset_sin", 32'(sin), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd0);
      chk("reset_rd_valid", 32'(rd_valid), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_rd_data", 32'(rd_data), 32'd0);

      // in_valid in IDLE must not be consumed.
      in_valid = 1'b1;
      in_data  = 8'h55;
      repeat (4) begin
         @(negedge sclk);
         chk("idle_in_ready", 32'(in_ready), 32'd0);
         chk("idle_busy", 32'(busy), 32'd0);
         chk("idle_ssel", 32'(ssel), 32'd0);
      end
      in_valid = 1'b0;

      for (int i = 0; i < int'(NB); i++) fd[i] = 8'(31 - i);
      run_frame(0, -1, -1);
      check_index_pattern();

      pl_val = {NB{8'hA5}};
      pl_en = 1'b1;
      @(negedge sclk);
      pl_en = 1'b0;
      mb = pl_val;
      for (int i = 0; i < int'(NB); i++) fd[i] = 8'h3C;
      run_frame(0, -1, -1);

      for (int i = 0; i < int'(NB); i++) fd[i] = 8'(31 - i);
      run_frame(5, -1, -1);
      check_index_pattern();

      fill_random();
      fd[3] = 8'h81;
      run_frame(-1, -1, 5);

      fill_random();
      run_frame(-1, 10, -1);
      fill_random();
      run_frame(0, -1, -1);
      fill_random();
      run_frame(-1, -1, 17);

      repeat (3) @(negedge sclk);
      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
